// File: rtl/dot_product_feeder.sv
// Serial dot-product feeder: streams one A/B vector pair into the engine and returns the per-vector result.
// Optional WAIT-state timeout is built only when DOT_FEED_TIMEOUT_EN is defined.
module dot_product_feeder #(
  parameter int WIDTH   = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 16,
  localparam int RES_W  = 2*WIDTH + $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [N*WIDTH-1:0] i_req_a,
  input  logic [N*WIDTH-1:0] i_req_b,
  output logic               o_elem_valid,
  output logic [WIDTH-1:0]   o_elem_a,
  output logic [WIDTH-1:0]   o_elem_b,
  input  logic [RES_W-1:0]   i_dp_result,
  input  logic               i_dp_valid,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [RES_W-1:0]   o_rsp_data,
  output logic               o_rsp_timeout,
  output logic               o_busy
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (N < 2 || TIMEOUT < 1) begin : g_param_check
    $error("dot_product_feeder: N must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_RESP} state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [N*WIDTH-1:0]   r_sh_a;
  logic [N*WIDTH-1:0]   r_sh_b;
  logic [RES_W-1:0]     r_base;
  logic                 r_elem_valid;
  logic [WIDTH-1:0]     r_elem_a;
  logic [WIDTH-1:0]     r_elem_b;
  logic                 r_rsp_valid;
  logic [RES_W-1:0]     r_rsp_data;

`ifdef DOT_FEED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_rsp_timeout;
  assign o_rsp_timeout = r_rsp_timeout;
`else
  assign o_rsp_timeout = 1'b0;
`endif

  assign o_req_ready  = (r_state == ST_IDLE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_elem_valid = r_elem_valid;
  assign o_elem_a     = r_elem_a;
  assign o_elem_b     = r_elem_b;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_sh_a       <= '0;
      r_sh_b       <= '0;
      r_base       <= '0;
      r_elem_valid <= 1'b0;
      r_elem_a     <= '0;
      r_elem_b     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
`ifdef DOT_FEED_TIMEOUT_EN
      r_cnt         <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            // Element 0 goes straight to the output; the shifters hold the rest.
            r_elem_valid <= 1'b1;
            r_elem_a     <= i_req_a[WIDTH-1:0];
            r_elem_b     <= i_req_b[WIDTH-1:0];
            r_sh_a       <= i_req_a >> WIDTH;
            r_sh_b       <= i_req_b >> WIDTH;
            r_idx        <= '0;
            r_state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (r_idx == LAST_IDX) begin
            r_elem_valid <= 1'b0;
            r_elem_a     <= '0;
            r_elem_b     <= '0;
            r_state      <= ST_WAIT;
`ifdef DOT_FEED_TIMEOUT_EN
            r_cnt        <= '0;
`endif
          end else begin
            r_elem_a <= r_sh_a[WIDTH-1:0];
            r_elem_b <= r_sh_b[WIDTH-1:0];
            r_sh_a   <= r_sh_a >> WIDTH;
            r_sh_b   <= r_sh_b >> WIDTH;
            r_idx    <= r_idx + 1'b1;
          end
        end
        ST_WAIT: begin
          // The engine total never clears, so the result is the delta from the last total.
          if (i_dp_valid) begin
            r_rsp_data  <= i_dp_result - r_base;
            r_base      <= i_dp_result;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
`ifdef DOT_FEED_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
`ifdef DOT_FEED_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_feeder.sv
// Directed bench for dot_product_feeder with a small accumulating engine model attached.
module tb_dot_product_feeder;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int RES_W = 2*WIDTH + $clog2(N);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic               elem_valid;
  logic [WIDTH-1:0]   elem_a;
  logic [WIDTH-1:0]   elem_b;
  logic [RES_W-1:0]   dp_result;
  logic               dp_valid;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [RES_W-1:0]   rsp_data;
  logic               rsp_timeout;
  logic               busy;

  logic               suppress;
  logic               stray;
  logic [RES_W-1:0]   eng_acc;
  logic               eng_prev;
  logic               eng_dv;
  logic               eng_in_vld;
  logic [RES_W-1:0]   eng_prod;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dot_product_feeder #(.WIDTH(WIDTH), .N(N), .TIMEOUT(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_elem_valid (elem_valid),
    .o_elem_a     (elem_a),
    .o_elem_b     (elem_b),
    .i_dp_result  (dp_result),
    .i_dp_valid   (dp_valid),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_timeout(rsp_timeout),
    .o_busy       (busy)
  );

  // Engine model: running total modulo 2^RES_W, pulses valid two cycles after a vector ends.
  assign eng_in_vld = elem_valid && !suppress;
  assign eng_prod   = RES_W'(elem_a) * RES_W'(elem_b);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng_acc  <= '0;
      eng_prev <= 1'b0;
      eng_dv   <= 1'b0;
    end else begin
      if (eng_in_vld) eng_acc <= eng_acc + eng_prod;
      eng_prev <= eng_in_vld;
      eng_dv   <= eng_prev && !eng_in_vld;
    end
  end
  assign dp_valid  = eng_dv | stray;
  assign dp_result = stray ? RES_W'(99) : eng_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accept edge, with element 0 on the outputs.
  task automatic send(input logic [N*WIDTH-1:0] a, input logic [N*WIDTH-1:0] b);
    int n = 0;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    while (!req_ready && n < 64) begin
      tick();
      n++;
    end
    if (!req_ready) chk("req_ready_wait", 0, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input logic [31:0] exp, input logic exp_to);
    int n = 0;
    while (!rsp_valid && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, 32'(rsp_valid), 1);
    chk({tag, "_data"}, 32'(rsp_data), exp);
    chk({tag, "_to"}, 32'(rsp_timeout), 32'(exp_to));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_idle_vld"}, 32'(rsp_valid), 0);
    chk({tag, "_idle_data"}, 32'(rsp_data), 0);
  endtask

  localparam logic [N*WIDTH-1:0] VA   = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [N*WIDTH-1:0] VB   = {8'd8, 8'd7, 8'd6, 8'd5};
  localparam logic [N*WIDTH-1:0] VMAX = {N*WIDTH{1'b1}};

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    suppress = 1'b0;
    stray = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_elem_valid", 32'(elem_valid), 0);
    chk("rst_elem_a", 32'(elem_a), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);

    // Basic vector with per-element checks
    send(VA, VB);
    for (int k = 0; k < N; k++) begin
      chk("elem_valid", 32'(elem_valid), 1);
      chk("elem_a", 32'(elem_a), 32'(k + 1));
      chk("elem_b", 32'(elem_b), 32'(k + 5));
      chk("busy_send", 32'(busy), 1);
      tick();
    end
    chk("elem_valid_after", 32'(elem_valid), 0);
    chk("elem_a_after", 32'(elem_a), 0);
    get_rsp("basic", 70, 1'b0);

    // Running-total wrap: 70+260100 = 260170, +260100 wraps to 258126
    send(VMAX, VMAX);
    get_rsp("max1", 260100, 1'b0);
    send(VMAX, VMAX);
    get_rsp("max2", 260100, 1'b0);
    chk("eng_wrapped", 32'(eng_acc), 258126);

    // Response backpressure
    send(VA, VB);
    begin
      int n = 0;
      while (!rsp_valid && n < 64) begin
        tick();
        n++;
      end
    end
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_vld", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 70);
      chk("bp_req_ready", 32'(req_ready), 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_idle_ready", 32'(req_ready), 1);
    chk("bp_idle_vld", 32'(rsp_valid), 0);

    // Stray dp_valid while idle must be ignored
    stray = 1'b1;
    tick();
    stray = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stray_vld", 32'(rsp_valid), 0);
      chk("stray_busy", 32'(busy), 0);
      tick();
    end
    send(VA, VB);
    get_rsp("after_stray", 70, 1'b0);

`ifdef DOT_FEED_TIMEOUT_EN
    suppress = 1'b1;
    send(VA, VB);
    begin
      int n = 0;
      while (elem_valid && n < 16) begin
        tick();
        n++;
      end
      n = 0;
      while (!rsp_valid && n < 64) begin
        tick();
        n++;
      end
      chk("to_cycles", 32'(n), 16);
    end
    get_rsp("timeout", 0, 1'b1);
    suppress = 1'b0;
    send({8'd1, 8'd1, 8'd2, 8'd3}, {8'd1, 8'd1, 8'd1, 8'd1});
    get_rsp("after_to", 7, 1'b0);
`endif

    // Reset mid-SEND after two elements
    send(VA, VB);
    tick();
    chk("mid_elem_a", 32'(elem_a), 2);
    rst_n = 1'b0;
    tick();
    chk("mrst_elem_valid", 32'(elem_valid), 0);
    chk("mrst_req_ready", 32'(req_ready), 1);
    chk("mrst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();
    send(VA, VB);
    get_rsp("after_rst", 70, 1'b0);

    send({8'd0, 8'd10, 8'd0, 8'd3}, {8'd9, 8'd2, 8'd9, 8'd4});
    get_rsp("sparse", 32, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
